// File: rtl/health_bar_renderer.sv
// Per-fighter health state, hit handshake, invulnerability flash,
// lagging ghost segment and registered health-bar pixel stream.
module health_bar_renderer #(
  parameter int MAX_HEALTH   = 100,
  parameter int PX_PER_HP    = 2,
  parameter int BAR_X        = 16,
  parameter int BAR_Y        = 16,
  parameter int BAR_H        = 12,
  parameter int FLASH_FRAMES = 8,
  parameter int DRAIN_PERIOD = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        frame_start_in,
  input  logic        game_reset_in,
  input  logic        hit_valid_in,
  input  logic [7:0]  hit_dmg_in,
  output logic        hit_ready_out,
  output logic [7:0]  health_out,
  output logic        ko_out,
  output logic [23:0] pixel_out
);

  localparam int BAR_W = MAX_HEALTH * PX_PER_HP;
  localparam int FC_W  = $clog2(FLASH_FRAMES + 1);
  localparam int DC_W  = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;

  localparam logic [7:0]      MAXH    = 8'(MAX_HEALTH);
  localparam logic [15:0]     PX16    = 16'(PX_PER_HP);
  localparam logic [10:0]     X0      = 11'(BAR_X);
  localparam logic [11:0]     X1      = 12'(BAR_X + BAR_W);
  localparam logic [9:0]      Y0      = 10'(BAR_Y);
  localparam logic [10:0]     Y1      = 11'(BAR_Y + BAR_H);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLASH_FRAMES - 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DRAIN_PERIOD - 1);

  localparam logic [23:0] C_HP    = 24'h00C000;
  localparam logic [23:0] C_FLASH = 24'hFFFFFF;
  localparam logic [23:0] C_GHOST = 24'hFFC000;
  localparam logic [23:0] C_EMPTY = 24'h400000;

  typedef enum logic [1:0] {
    ALIVE,
    COOLDOWN,
    KO
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      health_q, health_d;
  logic [7:0]      ghost_q, ghost_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic [DC_W-1:0] dcnt_q, dcnt_d;
  logic [23:0]     pix_d;

  logic        accept;
  logic [7:0]  dmg_res;
  logic        in_bar;
  logic        flash;
  logic        lt_h;
  logic        lt_g;
  logic [10:0] off;
  logic [15:0] h_thr;
  logic [15:0] g_thr;

  assign hit_ready_out = (state_q == ALIVE) && !game_reset_in;
  assign accept        = hit_valid_in && hit_ready_out;
  assign dmg_res       = (hit_dmg_in >= health_q) ? 8'd0
                       : health_q - hit_dmg_in;
  assign health_out    = health_q;
  assign ko_out        = (state_q == KO);

  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    ghost_d  = ghost_q;
    fcnt_d   = fcnt_q;
    dcnt_d   = dcnt_q;
    if (game_reset_in) begin
      state_d  = ALIVE;
      health_d = MAXH;
      ghost_d  = MAXH;
      fcnt_d   = '0;
      dcnt_d   = '0;
    end else begin
      // ghost compares against pre-hit health; still >= post-hit health
      if (frame_start_in) begin
        if (dcnt_q == DC_LAST) begin
          dcnt_d = '0;
          if (ghost_q > health_q) ghost_d = ghost_q - 8'd1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      unique case (state_q)
        ALIVE: begin
          if (accept && hit_dmg_in != 8'd0) begin
            health_d = dmg_res;
            fcnt_d   = '0;
            state_d  = (dmg_res == 8'd0) ? KO : COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (frame_start_in) begin
            if (fcnt_q == FC_LAST) begin
              fcnt_d  = '0;
              state_d = ALIVE;
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end
        end
        KO: state_d = KO;
        default: state_d = ALIVE;
      endcase
    end
  end

  assign off    = hcount_in - X0;
  assign h_thr  = {8'd0, health_q} * PX16;
  assign g_thr  = {8'd0, ghost_q} * PX16;
  assign lt_h   = {5'd0, off} < h_thr;
  assign lt_g   = {5'd0, off} < g_thr;
  assign flash  = (state_q == COOLDOWN) && fcnt_q[0];
  assign in_bar = (hcount_in >= X0) && ({1'b0, hcount_in} < X1)
               && (vcount_in >= Y0) && ({1'b0, vcount_in} < Y1);

  always_comb begin
    pix_d = 24'h000000;
    unique case (1'b1)
      !in_bar:                 pix_d = 24'h000000;
      in_bar && lt_h && flash:  pix_d = C_FLASH;
      in_bar && lt_h && !flash: pix_d = C_HP;
      in_bar && !lt_h && lt_g:  pix_d = C_GHOST;
      in_bar && !lt_h && !lt_g: pix_d = C_EMPTY;
      default:                 pix_d = 24'h000000;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ALIVE;
      health_q  <= MAXH;
      ghost_q   <= MAXH;
      fcnt_q    <= '0;
      dcnt_q    <= '0;
      pixel_out <= 24'h000000;
    end else begin
      state_q   <= state_d;
      health_q  <= health_d;
      ghost_q   <= ghost_d;
      fcnt_q    <= fcnt_d;
      dcnt_q    <= dcnt_d;
      pixel_out <= pix_d;
    end
  end

endmodule

// File: tb/tb_health_bar_renderer.sv
// Randomized bench for health_bar_renderer against a frame-level
// behavioural model of health, invulnerability and ghost drain.
module tb_health_bar_renderer;

  localparam int MAXH = 100;
  localparam int PX   = 2;
  localparam int BX   = 16;
  localparam int BY   = 16;
  localparam int BH   = 12;
  localparam int FF   = 8;
  localparam int DP   = 2;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        frame_start_in;
  logic        game_reset_in;
  logic        hit_valid_in;
  logic [7:0]  hit_dmg_in;
  logic        hit_ready_out;
  logic [7:0]  health_out;
  logic        ko_out;
  logic [23:0] pixel_out;

  int n_cmp = 0;
  int n_bad = 0;

  int m_health;
  int m_ghost;
  bit m_cool;
  int m_seen;
  bit m_ko;
  int m_frames;

  health_bar_renderer #(
    .MAX_HEALTH(MAXH), .PX_PER_HP(PX), .BAR_X(BX), .BAR_Y(BY),
    .BAR_H(BH), .FLASH_FRAMES(FF), .DRAIN_PERIOD(DP)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .hcount_in(hcount_in),
    .vcount_in(vcount_in),
    .frame_start_in(frame_start_in),
    .game_reset_in(game_reset_in),
    .hit_valid_in(hit_valid_in),
    .hit_dmg_in(hit_dmg_in),
    .hit_ready_out(hit_ready_out),
    .health_out(health_out),
    .ko_out(ko_out),
    .pixel_out(pixel_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_health = MAXH;
    m_ghost  = MAXH;
    m_cool   = 0;
    m_seen   = 0;
    m_ko     = 0;
    m_frames = 0;
  endfunction

  function automatic bit ref_ready(bit gr);
    return !m_ko && !m_cool && !gr;
  endfunction

  function automatic logic [23:0] ref_pix(int h, int v);
    int o;
    if (h < BX || h >= BX + MAXH * PX || v < BY || v >= BY + BH)
      return 24'h000000;
    o = h - BX;
    if (o < m_health * PX)
      return (m_cool && (m_seen % 2 == 1)) ? 24'hFFFFFF : 24'h00C000;
    if (o < m_ghost * PX) return 24'hFFC000;
    return 24'h400000;
  endfunction

  function automatic void model_step(bit fs, bit gr, bit hv, int dmg);
    bit rdy;
    int old_h;
    rdy = ref_ready(gr);
    if (gr) begin
      model_reset();
      return;
    end
    old_h = m_health;
    if (fs) begin
      m_frames++;
      if (m_frames % DP == 0 && m_ghost > old_h) m_ghost--;
      if (m_cool) begin
        m_seen++;
        if (m_seen == FF) begin
          m_cool = 0;
          m_seen = 0;
        end
      end
    end
    if (hv && rdy && dmg > 0) begin
      m_health = (dmg >= m_health) ? 0 : m_health - dmg;
      if (m_health == 0) m_ko = 1;
      else begin
        m_cool = 1;
        m_seen = 0;
      end
    end
  endfunction

  task automatic cycle(input bit fs, input bit gr, input bit hv,
                       input int dmg, input int h, input int v);
    logic [23:0] exp_pix;
    frame_start_in = fs;
    game_reset_in  = gr;
    hit_valid_in   = hv;
    hit_dmg_in     = 8'(dmg);
    hcount_in      = 11'(h);
    vcount_in      = 10'(v);
    #1;
    chk("ready", {31'd0, hit_ready_out}, {31'd0, ref_ready(gr)});
    exp_pix = ref_pix(h, v);
    model_step(fs, gr, hv, dmg);
    @(posedge clk_in);
    #1;
    chk("health", {24'd0, health_out}, 32'(m_health));
    chk("ko", {31'd0, ko_out}, {31'd0, m_ko});
    chk("pixel", {8'd0, pixel_out}, {8'd0, exp_pix});
  endtask

  task automatic frames(input int n, input int h, input int v);
    for (int i = 0; i < n; i++) begin
      cycle(1, 0, 0, 0, h, v);
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, h, v);
    end
  endtask

  task automatic async_reset();
    frame_start_in = 0;
    game_reset_in  = 0;
    hit_valid_in   = 0;
    #2;
    rst_n_in = 0;
    #1;
    model_reset();
    chk("rst_health", {24'd0, health_out}, 32'(MAXH));
    chk("rst_pixel", {8'd0, pixel_out}, 32'd0);
    chk("rst_ko", {31'd0, ko_out}, 32'd0);
    chk("rst_ready", {31'd0, hit_ready_out}, 32'd1);
    @(negedge clk_in);
    rst_n_in = 1;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_n_in       = 1;
    hcount_in      = 0;
    vcount_in      = 0;
    frame_start_in = 0;
    game_reset_in  = 0;
    hit_valid_in   = 0;
    hit_dmg_in     = 0;
    @(posedge clk_in);
    async_reset();

    cycle(0, 0, 0, 0, BX + 10, BY + 1);
    chk("first_pix", {8'd0, pixel_out}, 32'h00C000);

    cycle(0, 0, 1, 30, BX + 10, BY + 1);
    chk("hit30", {24'd0, health_out}, 32'd70);
    frames(FF, BX + 10, BY + 1);
    chk("ready_after_cd", {31'd0, hit_ready_out}, 32'd1);
    cycle(0, 0, 0, 0, BX + 150, BY + 2);
    chk("ghost_pix", {8'd0, pixel_out}, 32'hFFC000);
    frames(60, BX + 150, BY + 2);
    chk("ghost_done", {8'd0, pixel_out}, 32'h400000);

    cycle(0, 0, 1, 50, BX + 5, BY);
    frames(FF, BX + 5, BY);
    cycle(0, 0, 1, 50, BX + 5, BY);
    chk("ko_set", {31'd0, ko_out}, 32'd1);
    for (int i = 0; i < 4; i++) cycle(i[0], 0, 1, 5, BX + 1, BY + 3);
    cycle(0, 1, 0, 0, BX + 1, BY + 3);
    chk("greset", {24'd0, health_out}, 32'd100);

    cycle(0, 1, 1, 40, BX, BY);
    chk("hit_vs_greset", {24'd0, health_out}, 32'd100);
    cycle(1, 0, 1, 10, BX, BY);
    frames(FF - 1, BX, BY);
    chk("fs_not_counted", {31'd0, hit_ready_out}, 32'd0);
    frames(1, BX, BY);

    cycle(0, 0, 1, 25, BX + 20, BY + 4);
    frames(3, BX + 20, BY + 4);
    async_reset();

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 7) == 0,
            $urandom_range(0, 249) == 0,
            $urandom_range(0, 5) == 0,
            int'($urandom_range(0, 40)),
            int'($urandom_range(0, 260)),
            int'($urandom_range(BY - 4, BY + BH + 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
